// File: rtl/controlador_io.sv
// I/O controller for a single-cycle CPU: IN stalls the core until the debounced
// enter button is pressed and released, capturing the switches; OUT latches the display.
module controlador_io #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        OpIO,
    input  logic        Halt,
    input  logic [31:0] DadoOut,
    input  logic [15:0] Switches,
    input  logic        BotaoEnter,
    output logic [31:0] DadoIn,
    output logic        Pausa,
    output logic        Atendido,
    output logic [31:0] Display,
    output logic        DisplayValido,
    output logic [1:0]  o_estado
);

    localparam int              CW = 20;
    localparam logic [CW-1:0]   TC = CW'(DEBOUNCE_CYCLES - 1);

    // o_estado encoding: 0 OCIOSO, 1 ESPERA_PRESS, 2 ESPERA_SOLTA, 3 LIBERA
    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        ESPERA_PRESS = 2'd1,
        ESPERA_SOLTA = 2'd2,
        LIBERA       = 2'd3
    } estado_t;

    estado_t        r_estado;
    estado_t        w_prox;
    logic           r_btn_s1;
    logic           r_btn_s2;
    logic [15:0]    r_sw_s1;
    logic [15:0]    r_sw_s2;
    logic           r_filt;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_dado_in;
    logic [31:0]    r_display;
    logic           r_display_valido;

    logic           w_diff;
    logic           w_tc;
    logic           w_sobe;
    logic           w_desce;
    logic           w_pausa;
    logic           w_atendido;
    logic           w_captura;
    logic           w_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= BotaoEnter;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= Switches;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // The edge events fire on the same clock edge that flips r_filt.
    assign w_diff  = (r_btn_s2 != r_filt);
    assign w_tc    = (r_cnt == TC);
    assign w_sobe  = w_diff && w_tc && !r_filt;
    assign w_desce = w_diff && w_tc && r_filt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (!w_diff) begin
            r_cnt  <= '0;
        end else if (w_tc) begin
            r_filt <= ~r_filt;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    always_comb begin
        w_prox     = r_estado;
        w_pausa    = 1'b0;
        w_atendido = 1'b0;
        w_captura  = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (OpIO && Halt) begin
                    w_prox  = ESPERA_PRESS;
                    w_pausa = 1'b1;
                end
            end
            ESPERA_PRESS: begin
                w_pausa = 1'b1;
                if (w_sobe) begin
                    w_prox    = ESPERA_SOLTA;
                    w_captura = 1'b1;
                end
            end
            ESPERA_SOLTA: begin
                w_pausa = 1'b1;
                if (w_desce) w_prox = LIBERA;
            end
            LIBERA: begin
                w_atendido = 1'b1;
                w_prox     = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
    end

    assign w_out = OpIO && !Halt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dado_in        <= '0;
            r_display        <= '0;
            r_display_valido <= 1'b0;
        end else begin
            if (w_captura) r_dado_in <= {16'b0, r_sw_s2};
            if (w_out) begin
                r_display        <= DadoOut;
                r_display_valido <= 1'b1;
            end
        end
    end

    // Reset gates the stall directly so it drops without waiting for a clock.
    assign Pausa         = w_pausa && reset;
    assign Atendido      = w_atendido;
    assign DadoIn        = r_dado_in;
    assign Display       = r_display;
    assign DisplayValido = r_display_valido;
    assign o_estado      = r_estado;

endmodule
